bcd_scan_ctrl: RTL and testbench

- Sequencer for the board's multi-digit 7-segment display.
- Accepts a binary value over a valid/ready handshake and converts it to BCD serially using shift-add-3 (double dabble), one bit per clock.
- Latches the result into a display register and time-multiplexes a single segment decoder across NDIG digit enables.
- Replaces per-digit combinational converters when the value is wider than 4 bits.

---
 rtl/bcd_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: binary-to-BCD sequencer for a multiplexed 7-segment display.
// A value arrives over a valid/ready handshake, is converted serially with the
// shift-add-3 (double dabble) method one bit per clock, and is then latched into
// a display register that a free-running scanner walks across NDIG digits.
// Optional macro BCD_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module bcd_scan_ctrl #(
   parameter int VAL_W    = 16,
   parameter int NDIG     = 5,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [VAL_W-1:0] val_in,
   input  logic             val_valid,
   output logic             val_ready,
   output logic             busy,
   output logic [0:6]       seg,
   output logic [NDIG-1:0]  dig_en
);

   localparam int BCD_W  = 4 * NDIG;
   localparam int CNT_W  = $clog2(VAL_W + 1);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(VAL_W - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      LOAD
   } state_t;

   state_t             state;
   logic [VAL_W-1:0]   shift_reg;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   bcd_adj;
   logic [CNT_W-1:0]   bit_cnt;
   logic [BCD_W-1:0]   disp;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]   dig_idx;
   logic [3:0]         cur_nib;
   logic               blank;
   logic [0:6]         next_seg;
   logic [NDIG-1:0]    next_en;

   // Segment pattern for one decimal digit, a..g left to right, active-low.
   function automatic logic [0:6] seg_code(input logic [3:0] nib);
      logic [0:6] code;
      case (nib)
         4'd0:    code = 7'b0000001;
         4'd1:    code = 7'b1001111;
         4'd2:    code = 7'b0010010;
         4'd3:    code = 7'b0000110;
         4'd4:    code = 7'b1001100;
         4'd5:    code = 7'b0100100;
         4'd6:    code = 7'b0100000;
         4'd7:    code = 7'b0001111;
         4'd8:    code = 7'b0000000;
         4'd9:    code = 7'b0000100;
         default: code = 7'b1111111;
      endcase
      return code;
   endfunction

   // Add-3 correction: every BCD nibble of 5 or more gets 3 added before the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM: capture in IDLE, one shift per clock in CONV, publish in LOAD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         shift_reg <= '0;
         bcd       <= '0;
         bit_cnt   <= '0;
         disp      <= '0;
         val_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (val_valid && val_ready) begin
                  shift_reg <= val_in;
                  bcd       <= '0;
                  bit_cnt   <= '0;
                  val_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= CONV;
               end
            end
            CONV: begin
               {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
               bit_cnt          <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               disp      <= bcd;
               val_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               val_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef BCD_SCAN_LZ_BLANK_EN
   // A digit is blank when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if ((i >= int'(dig_idx)) && (disp[4*i +: 4] != 4'd0)) begin
            upper_zero = 1'b0;
         end
      end
      blank = (dig_idx != '0) && upper_zero;
   end
`else
   assign blank = 1'b0;
`endif

   // Pattern and enable for the digit currently selected by the scanner.
   always_comb begin
      cur_nib          = disp[4*int'(dig_idx) +: 4];
      next_seg         = blank ? 7'b1111111 : seg_code(cur_nib);
      next_en          = '1;
      next_en[dig_idx] = 1'b0;
   end

   // Free-running scanner with registered segment and digit-enable outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_cnt <= '0;
         dig_idx  <= '0;
         seg      <= 7'b1111111;
         dig_en   <= '1;
      end else begin
         seg    <= next_seg;
         dig_en <= next_en;
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: randomized and directed stimulus for bcd_scan_ctrl, checked
// every cycle against a decimal-arithmetic model of what the display must show.
module tb_bcd_scan_ctrl;

   localparam int VAL_W    = 16;
   localparam int NDIG     = 5;
   localparam int SCAN_DIV = 4;

   logic             clk;
   logic             reset_n;
   logic [VAL_W-1:0] val_in;
   logic             val_valid;
   logic             val_ready;
   logic             busy;
   logic [0:6]       seg;
   logic [NDIG-1:0]  dig_en;

   int checks = 0;
   int passes = 0;

   // Model state: edges since reset release, handshake availability, shown value.
   int         m_edges   = 0;
   bit         m_ready   = 1'b1;
   int         m_left    = 0;
   int         m_pending = 0;
   int         m_disp    = 0;
   logic [0:6]      exp_seg = 7'b1111111;
   logic [NDIG-1:0] exp_en  = '1;

   bcd_scan_ctrl #(
      .VAL_W   (VAL_W),
      .NDIG    (NDIG),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .val_in   (val_in),
      .val_valid(val_valid),
      .val_ready(val_ready),
      .busy     (busy),
      .seg      (seg),
      .dig_en   (dig_en)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [0:6] segOf(input int digit);
      logic [0:6] c;
      case (digit)
         0: c = 7'b0000001;
         1: c = 7'b1001111;
         2: c = 7'b0010010;
         3: c = 7'b0000110;
         4: c = 7'b1001100;
         5: c = 7'b0100100;
         6: c = 7'b0100000;
         7: c = 7'b0001111;
         8: c = 7'b0000000;
         9: c = 7'b0000100;
         default: c = 7'b1111111;
      endcase
      return c;
   endfunction

   function automatic int pow10(input int d);
      int p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   // What the display must show for digit d of a decimal value.
   function automatic logic [0:6] expectedSeg(input int v, input int d);
`ifdef BCD_SCAN_LZ_BLANK_EN
      if (d > 0 && v < pow10(d)) return 7'b1111111;
`endif
      return segOf((v / pow10(d)) % 10);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
   endtask

   // Behavioural model: digit position from elapsed edges, conversion as a fixed delay.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_edges = 0;
         m_ready = 1'b1;
         m_left  = 0;
         m_disp  = 0;
         exp_seg = 7'b1111111;
         exp_en  = '1;
      end else begin
         int d;
         m_edges++;
         d       = ((m_edges - 1) / SCAN_DIV) % NDIG;
         exp_en  = ~(NDIG'(1) << d);
         exp_seg = expectedSeg(m_disp, d);
         if (m_ready) begin
            if (val_valid) begin
               m_ready   = 1'b0;
               m_pending = int'(val_in);
               m_left    = VAL_W + 1;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_disp  = m_pending;
               m_ready = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("dig_en", 32'(dig_en), 32'(exp_en));
      checkOutput("seg", 32'(seg), 32'(exp_seg));
      checkOutput("val_ready", 32'(val_ready), 32'(m_ready));
      checkOutput("busy", 32'(busy), 32'(!m_ready));
   end

   // Offer a value and hold it until the block is ready, then drop valid.
   task automatic applyStimulus(input logic [VAL_W-1:0] v);
      int n = 0;
      while (!val_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         $display("[TB] FAIL accept_timeout: val_ready stayed %0b, required 1", val_ready);
      end
      val_in    = v;
      val_valid = 1'b1;
      @(negedge clk);
      val_valid = 1'b0;
   endtask

   task automatic waitDigit(input int d);
      int n = 0;
      logic [NDIG-1:0] want;
      want = ~(NDIG'(1) << d);
      while (dig_en !== want && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         $display("[TB] FAIL digit_timeout: dig_en %b, required %b", dig_en, want);
      end
   endtask

   task automatic checkDigit(input int d, input logic [0:6] code, input string name);
      waitDigit(d);
      checkOutput(name, 32'(seg), 32'(code));
   endtask

   initial begin
      int lowCycles;
      reset_n   = 1'b0;
      val_valid = 1'b0;
      val_in    = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_seg", 32'(seg), 32'h7F);
      checkOutput("reset_dig_en", 32'(dig_en), 32'h1F);
      checkOutput("reset_ready", 32'(val_ready), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      #1 reset_n = 1'b1;
      @(negedge clk);
      checkOutput("first_dig_en", 32'(dig_en), 32'b11110);
      checkOutput("first_seg", 32'(seg), 32'b0000001);
      repeat (4) @(negedge clk);
      checkOutput("second_dig_en", 32'(dig_en), 32'b11101);

      // 12345: ready low for VAL_W+1 cycles, then digits 5 and 1 at the ends.
      applyStimulus(16'd12345);
      lowCycles = 0;
      while (!val_ready && lowCycles < 100) begin
         lowCycles++;
         @(negedge clk);
      end
      checkOutput("ready_low_cycles", 32'(lowCycles), 32'd17);
      repeat (2) @(negedge clk);
      checkDigit(0, 7'b0100100, "12345_d0");
      checkDigit(4, 7'b1001111, "12345_d4");

      // 65535: full-scale, digits 6,5,5,3,5.
      applyStimulus(16'd65535);
      repeat (20) @(negedge clk);
      checkDigit(0, 7'b0100100, "65535_d0");
      checkDigit(1, 7'b0000110, "65535_d1");
      checkDigit(2, 7'b0100100, "65535_d2");
      checkDigit(3, 7'b0100100, "65535_d3");
      checkDigit(4, 7'b0100000, "65535_d4");

      // 9 offered during conversion of 777 waits until the block is ready again.
      applyStimulus(16'd777);
      repeat (3) @(negedge clk);
      val_in    = 16'd9;
      val_valid = 1'b1;
      while (!val_ready) @(negedge clk);
      @(negedge clk);
      val_valid = 1'b0;
      checkOutput("busy_on_9", 32'(busy), 32'd1);
      repeat (20) @(negedge clk);
      checkDigit(0, 7'b0000100, "nine_d0");

      // Reset in the middle of converting 40000 clears the display.
      applyStimulus(16'd40000);
      repeat (7) @(negedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset_seg", 32'(seg), 32'h7F);
      checkOutput("midreset_dig_en", 32'(dig_en), 32'h1F);
      checkOutput("midreset_ready", 32'(val_ready), 32'd1);
      #1 reset_n = 1'b1;
      repeat (30) @(negedge clk);
      checkDigit(0, 7'b0000001, "after_reset_d0");
`ifdef BCD_SCAN_LZ_BLANK_EN
      checkDigit(2, 7'b1111111, "after_reset_d2");
`else
      checkDigit(2, 7'b0000001, "after_reset_d2");
`endif

`ifdef BCD_SCAN_LZ_BLANK_EN
      applyStimulus(16'd42);
      repeat (20) @(negedge clk);
      checkDigit(0, 7'b0010010, "lz42_d0");
      checkDigit(1, 7'b1001100, "lz42_d1");
      checkDigit(2, 7'b1111111, "lz42_d2");
      checkDigit(3, 7'b1111111, "lz42_d3");
      checkDigit(4, 7'b1111111, "lz42_d4");
`endif

      // Random traffic, including valid held high across several conversions.
      for (int i = 0; i < 40; i++) begin
         val_in    = VAL_W'($urandom);
         val_valid = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 30)) @(negedge clk);
      end
      val_valid = 1'b0;
      repeat (60) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
